// File: rtl/pipelined_bk_adder_if.sv
// Operand/result handshake bundle for pipelined_bk_adder.
// The ovf signal exists only when BK_OVERFLOW_EN is defined.
interface pipelined_bk_adder_if #(
   parameter int WIDTH = 64
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
`ifdef BK_OVERFLOW_EN
   logic             ovf;

   modport master (
      output in_valid, A, B, Cin, sub, out_ready,
      input  in_ready, out_valid, Sum, Cout, ovf
   );

   modport slave (
      input  in_valid, A, B, Cin, sub, out_ready,
      output in_ready, out_valid, Sum, Cout, ovf
   );
`else
   modport master (
      output in_valid, A, B, Cin, sub, out_ready,
      input  in_ready, out_valid, Sum, Cout
   );

   modport slave (
      input  in_valid, A, B, Cin, sub, out_ready,
      output in_ready, out_valid, Sum, Cout
   );
`endif
endinterface

// File: rtl/pipelined_bk_adder.sv
// Brent-Kung prefix adder split over STAGES elastic pipeline stages with valid/ready flow control.
// Define BK_OVERFLOW_EN to add the pipelined signed-overflow output ovf.
module pipelined_bk_adder #(
   parameter int WIDTH  = 64,
   parameter int STAGES = 2
) (
   input logic                 clk,
   input logic                 rst,
   pipelined_bk_adder_if.slave bus
);
   localparam int LOGW   = $clog2(WIDTH);
   localparam int LEVELS = 2 * LOGW - 1;

   typedef struct packed {
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH-1:0] hs;
      logic             cin;
   } stage_t;

   // Last prefix level finished by stage k; earlier stages absorb the remainder.
   function automatic int stage_end(input int k);
      int base;
      int ext;
      base = LEVELS / STAGES;
      ext  = LEVELS % STAGES;
      return (k + 1) * base + (((k + 1) < ext) ? (k + 1) : ext);
   endfunction

   // One Brent-Kung level: 1..LOGW is the up-sweep, the rest the down-sweep.
   function automatic logic [2*WIDTH-1:0] bk_level(input int lvl,
                                                   input logic [WIDTH-1:0] g,
                                                   input logic [WIDTH-1:0] p);
      logic [WIDTH-1:0] g_n;
      logic [WIDTH-1:0] p_n;
      logic [LOGW-1:0]  j;
      int               span;
      bit               hit;
      g_n = g;
      p_n = p;
      for (int i = 0; i < WIDTH; i++) begin
         hit = 1'b0;
         j   = '0;
         if (lvl <= LOGW) begin
            span = 1 << lvl;
            if (((i + 1) % span) == 0) begin
               hit = 1'b1;
               j   = LOGW'(i - span / 2);
            end
         end else begin
            span = 1 << (LEVELS - lvl);
            if ((((i + 1) % (2 * span)) == span) && (i >= 2 * span)) begin
               hit = 1'b1;
               j   = LOGW'(i - span);
            end
         end
         if (hit) begin
            g_n[i] = g[i] | (p[i] & g[j]);
            p_n[i] = p[i] & p[j];
         end
      end
      return {g_n, p_n};
   endfunction

   logic [STAGES:0]   load;
   logic [STAGES-1:0] vld_p;
   logic [STAGES-1:0] take_v;
   logic [WIDTH-1:0]  bb;
   stage_t            lvl0;
   logic [WIDTH-1:0]  sum_d;
   logic              cout_d;
   logic [WIDTH-1:0]  sum_q;
   logic              cout_q;
`ifdef BK_OVERFLOW_EN
   logic              ovf_d;
   logic              ovf_q;
`endif

   // Carry-in is folded into bit 0's generate so every prefix G[i] is the carry out of bit i.
   always_comb begin
      bb       = bus.sub ? ~bus.B : bus.B;
      lvl0.g   = bus.A & bb;
      lvl0.p   = bus.A ^ bb;
      lvl0.hs  = bus.A ^ bb;
      lvl0.cin = bus.Cin;
      lvl0.g[0] = lvl0.g[0] | (lvl0.p[0] & bus.Cin);
   end

   // A stage loads when empty or when its content moves on this same edge.
   always_comb begin
      load = '0;
      load[STAGES] = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k] = !vld_p[k] || load[k+1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) vld_p[k] <= take_v[k];
         end
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = (k == 0) ? 0 : stage_end(k - 1);
      localparam int HI = stage_end(k);
      stage_t d_in;

      if (k == 0) begin : g_src
         assign d_in      = lvl0;
         assign take_v[k] = bus.in_valid;
      end else begin : g_src
         assign d_in      = g_stage[k-1].g_reg.q_p;
         assign take_v[k] = vld_p[k-1];
      end

      if (k < STAGES - 1) begin : g_reg
         stage_t d_out;
         stage_t q_p;

         always_comb begin
            d_out = d_in;
            for (int l = LO + 1; l <= HI; l++) begin
               {d_out.g, d_out.p} = bk_level(l, d_out.g, d_out.p);
            end
         end

         // ---- register boundary after prefix level HI ----
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               q_p <= '0;
            end else if (load[k] && take_v[k]) begin
               q_p <= d_out;
            end
         end
      end else begin : g_out
         logic [WIDTH-1:0] g;
         logic [WIDTH-1:0] p;

         always_comb begin
            g = d_in.g;
            p = d_in.p;
            for (int l = LO + 1; l <= HI; l++) begin
               {g, p} = bk_level(l, g, p);
            end
         end

         assign sum_d  = d_in.hs ^ {g[WIDTH-2:0], d_in.cin};
         assign cout_d = g[WIDTH-1];
`ifdef BK_OVERFLOW_EN
         assign ovf_d  = g[WIDTH-1] ^ g[WIDTH-2];
`endif
      end
   end

   // ---- output register boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
`ifdef BK_OVERFLOW_EN
         ovf_q  <= 1'b0;
`endif
      end else if (load[STAGES-1] && take_v[STAGES-1]) begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
`ifdef BK_OVERFLOW_EN
         ovf_q  <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = load[0];
   assign bus.out_valid = vld_p[STAGES-1];
   assign bus.Sum       = sum_q;
   assign bus.Cout      = cout_q;
`ifdef BK_OVERFLOW_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_bk_adder.sv
// Self-checking bench for pipelined_bk_adder: directed 64-bit cases plus random 64/16-bit scoreboards.
module tb_pipelined_bk_adder;
   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   pipelined_bk_adder_if #(.WIDTH(64)) bus64 ();
   pipelined_bk_adder_if #(.WIDTH(16)) bus16a ();
   pipelined_bk_adder_if #(.WIDTH(16)) bus16b ();

   pipelined_bk_adder #(.WIDTH(64), .STAGES(2)) dut64   (.clk(clk), .rst(rst), .bus(bus64));
   pipelined_bk_adder #(.WIDTH(16), .STAGES(1)) dut16s1 (.clk(clk), .rst(rst), .bus(bus16a));
   pipelined_bk_adder #(.WIDTH(16), .STAGES(4)) dut16s4 (.clk(clk), .rst(rst), .bus(bus16b));

   typedef struct {
      logic [63:0] sum;
      logic        cout;
      logic        ovf;
   } res64_t;

   typedef struct {
      logic [16:0] r;
      int          c;
      bit          lat;
   } ent16_t;

   function automatic res64_t model64(input logic [63:0] a, input logic [63:0] b,
                                      input logic cin, input logic sub);
      res64_t      r;
      logic [63:0] bo;
      logic [64:0] u;
      logic [65:0] s;
      bo     = sub ? ~b : b;
      u      = {1'b0, a} + {1'b0, bo} + 65'(cin);
      s      = {{2{a[63]}}, a} + {{2{bo[63]}}, bo} + 66'(cin);
      r.sum  = u[63:0];
      r.cout = u[64];
      r.ovf  = (s[64] != s[63]);
      return r;
   endfunction

   function automatic logic [16:0] model16(input logic [15:0] a, input logic [15:0] b,
                                           input logic cin, input logic sub);
      return {1'b0, a} + {1'b0, (sub ? ~b : b)} + 17'(cin);
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set64(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub);
      bus64.in_valid = v;
      bus64.A        = a;
      bus64.B        = b;
      bus64.Cin      = cin;
      bus64.sub      = sub;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (bus64.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 1", bus64.in_ready); end
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", bus64.out_valid); end
      n_checks++;
      if (bus64.Sum !== 64'h0 || bus64.Cout !== 1'b0) begin
         n_fail++; $display("FAIL rst_sum: got %h/%b expected 0/0", bus64.Sum, bus64.Cout);
      end
      n_checks++;
      if (bus16b.out_valid !== 1'b0 || bus16b.Sum !== 16'h0) begin
         n_fail++; $display("FAIL rst_w16: got %b/%h expected 0/0", bus16b.out_valid, bus16b.Sum);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_carry_chain();
      bus64.out_ready = 1'b1;
      set64(1'b1, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 1'b1, 1'b0);
      #2;
      n_checks++;
      if (bus64.in_ready !== 1'b1) begin n_fail++; $display("FAIL cc_accept: got %b expected 1", bus64.in_ready); end
      tick();
      bus64.in_valid = 1'b0;
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL cc_early: got %b expected 0", bus64.out_valid); end
      tick();
      n_checks++;
      if (bus64.out_valid !== 1'b1 || bus64.Sum !== 64'h0 || bus64.Cout !== 1'b1) begin
         n_fail++; $display("FAIL cc_result: got v=%b %h c=%b expected v=1 0 c=1", bus64.out_valid, bus64.Sum, bus64.Cout);
      end
      tick();
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL cc_dup: got %b expected 0", bus64.out_valid); end
   endtask

   task automatic test_back_to_back();
      bus64.out_ready = 1'b1;
      set64(1'b1, 64'h1, 64'h1, 1'b1, 1'b0);
      tick();
      set64(1'b1, 64'h0, 64'h00000000FFFFFFFF, 1'b1, 1'b0);
      tick();
      bus64.in_valid = 1'b0;
      n_checks++;
      if (bus64.out_valid !== 1'b1 || bus64.Sum !== 64'h3 || bus64.Cout !== 1'b0) begin
         n_fail++; $display("FAIL b2b_first: got v=%b %h c=%b expected v=1 3 c=0", bus64.out_valid, bus64.Sum, bus64.Cout);
      end
      tick();
      n_checks++;
      if (bus64.out_valid !== 1'b1 || bus64.Sum !== 64'h0000000100000000 || bus64.Cout !== 1'b0) begin
         n_fail++; $display("FAIL b2b_second: got v=%b %h c=%b expected v=1 100000000 c=0", bus64.out_valid, bus64.Sum, bus64.Cout);
      end
      tick();
   endtask

   task automatic test_sub();
      bus64.out_ready = 1'b1;
      set64(1'b1, 64'h5, 64'h7, 1'b1, 1'b1);
      tick();
      set64(1'b1, 64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0);
      tick();
      bus64.in_valid = 1'b0;
      n_checks++;
      if (bus64.out_valid !== 1'b1 || bus64.Sum !== 64'hFFFFFFFFFFFFFFFE || bus64.Cout !== 1'b0) begin
         n_fail++; $display("FAIL sub_result: got v=%b %h c=%b expected v=1 fffffffffffffffe c=0", bus64.out_valid, bus64.Sum, bus64.Cout);
      end
`ifdef BK_OVERFLOW_EN
      n_checks++;
      if (bus64.ovf !== 1'b0) begin n_fail++; $display("FAIL sub_ovf: got %b expected 0", bus64.ovf); end
`endif
      tick();
      n_checks++;
      if (bus64.Sum !== 64'h8000000000000000 || bus64.Cout !== 1'b0) begin
         n_fail++; $display("FAIL ovf_sum: got %h c=%b expected 8000000000000000 c=0", bus64.Sum, bus64.Cout);
      end
`ifdef BK_OVERFLOW_EN
      n_checks++;
      if (bus64.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus64.ovf); end
`endif
      tick();
   endtask

   task automatic test_stall();
      logic [63:0] a [3];
      logic [63:0] b [3];
      res64_t      e [3];
      int          acc = 0;
      int          got = 0;
      bit          took;
      for (int i = 0; i < 3; i++) begin
         a[i] = rand64();
         b[i] = rand64();
         e[i] = model64(a[i], b[i], 1'b0, 1'b0);
      end
      bus64.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         set64(1'b1, a[acc], b[acc], 1'b0, 1'b0);
         #2;
         if (acc >= 2) begin
            n_checks++;
            if (bus64.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready: got %b expected 0", bus64.in_ready); end
            n_checks++;
            if (bus64.out_valid !== 1'b1 || bus64.Sum !== e[0].sum || bus64.Cout !== e[0].cout) begin
               n_fail++; $display("FAIL stall_hold: got v=%b %h c=%b expected v=1 %h c=%b", bus64.out_valid, bus64.Sum, bus64.Cout, e[0].sum, e[0].cout);
            end
         end
         took = bus64.in_ready;
         tick();
         if (took) acc++;
      end
      bus64.out_ready = 1'b1;
      for (int c = 0; c < 20 && got < 3; c++) begin
         bus64.in_valid = (acc < 3);
         if (acc < 3) begin bus64.A = a[acc]; bus64.B = b[acc]; end
         #2;
         took = bus64.in_valid && bus64.in_ready;
         if (bus64.out_valid) begin
            n_checks++;
            if (bus64.Sum !== e[got].sum || bus64.Cout !== e[got].cout) begin
               n_fail++; $display("FAIL stall_drain%0d: got %h c=%b expected %h c=%b", got, bus64.Sum, bus64.Cout, e[got].sum, e[got].cout);
            end
            got++;
         end
         tick();
         if (took) acc++;
      end
      bus64.in_valid = 1'b0;
      n_checks++;
      if (got != 3 || acc != 3) begin n_fail++; $display("FAIL stall_count: got out=%0d in=%0d expected 3/3", got, acc); end
      #2;
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_extra: got %b expected 0", bus64.out_valid); end
      tick();
   endtask

   task automatic test_reset_midflight();
      bus64.out_ready = 1'b1;
      set64(1'b1, 64'h5, 64'h6, 1'b0, 1'b0);
      tick();
      set64(1'b1, 64'h100, 64'h1, 1'b0, 1'b0);
      tick();
      bus64.in_valid = 1'b0;
      n_checks++;
      if (bus64.out_valid !== 1'b1 || bus64.Sum !== 64'hB) begin
         n_fail++; $display("FAIL mid_inflight: got v=%b %h expected v=1 b", bus64.out_valid, bus64.Sum);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus64.out_valid !== 1'b0 || bus64.Sum !== 64'h0 || bus64.Cout !== 1'b0 || bus64.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL mid_rst: got v=%b %h c=%b rdy=%b expected v=0 0 c=0 rdy=1", bus64.out_valid, bus64.Sum, bus64.Cout, bus64.in_ready);
      end
      tick();
      rst = 1'b0;
      set64(1'b1, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 1'b0);
      #2;
      n_checks++;
      if (bus64.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b expected 1", bus64.in_ready); end
      tick();
      bus64.in_valid = 1'b0;
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale: got %b expected 0", bus64.out_valid); end
      tick();
      n_checks++;
      if (bus64.out_valid !== 1'b1 || bus64.Sum !== 64'h0 || bus64.Cout !== 1'b1) begin
         n_fail++; $display("FAIL mid_new: got v=%b %h c=%b expected v=1 0 c=1", bus64.out_valid, bus64.Sum, bus64.Cout);
      end
      tick();
      n_checks++;
      if (bus64.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after: got %b expected 0", bus64.out_valid); end
   endtask

   task automatic test_random64();
      res64_t q [$];
      res64_t r;
      bit     in_x;
      bit     out_x;
      for (int cyc = 0; cyc < 400; cyc++) begin
         set64($urandom_range(0, 3) != 0, rand64(), rand64(), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 7) == 0) bus64.A = '1;
         if ($urandom_range(0, 7) == 0) bus64.B = 64'h8000000000000000;
         bus64.out_ready = ($urandom_range(0, 2) != 0) || (cyc >= 380);
         if (cyc >= 380) bus64.in_valid = 1'b0;
         #2;
         in_x  = bus64.in_valid && bus64.in_ready;
         out_x = bus64.out_valid && bus64.out_ready;
         if (in_x) q.push_back(model64(bus64.A, bus64.B, bus64.Cin, bus64.sub));
         if (out_x) begin
            n_checks++;
            if (q.size() == 0) begin
               n_fail++; $display("FAIL rand64_spurious: got %h expected no result", bus64.Sum);
            end else begin
               r = q.pop_front();
               if (bus64.Sum !== r.sum || bus64.Cout !== r.cout) begin
                  n_fail++; $display("FAIL rand64: got %h c=%b expected %h c=%b", bus64.Sum, bus64.Cout, r.sum, r.cout);
               end
`ifdef BK_OVERFLOW_EN
               n_checks++;
               if (bus64.ovf !== r.ovf) begin n_fail++; $display("FAIL rand64_ovf: got %b expected %b", bus64.ovf, r.ovf); end
`endif
            end
         end
         tick();
      end
      n_checks++;
      if (q.size() != 0) begin n_fail++; $display("FAIL rand64_lost: got %0d pending expected 0", q.size()); end
   endtask

   task automatic test_w16_random();
      ent16_t q1 [$];
      ent16_t q4 [$];
      ent16_t e;
      logic [16:0] exp_r;
      for (int cyc = 0; cyc < 500; cyc++) begin
         bus16a.in_valid = (cyc < 480) && ($urandom_range(0, 3) != 0);
         bus16a.A   = 16'($urandom);
         bus16a.B   = 16'($urandom);
         bus16a.Cin = 1'($urandom);
         bus16a.sub = 1'($urandom);
         bus16b.in_valid = bus16a.in_valid;
         bus16b.A   = bus16a.A;
         bus16b.B   = bus16a.B;
         bus16b.Cin = bus16a.Cin;
         bus16b.sub = bus16a.sub;
         bus16a.out_ready = (cyc < 200) || (cyc >= 480) || ($urandom_range(0, 2) != 0);
         bus16b.out_ready = (cyc < 200) || (cyc >= 480) || ($urandom_range(0, 2) != 0);
         #2;
         exp_r = model16(bus16a.A, bus16a.B, bus16a.Cin, bus16a.sub);
         if (bus16a.in_valid && bus16a.in_ready) q1.push_back('{exp_r, cyc, (cyc + 1 < 200)});
         if (bus16b.in_valid && bus16b.in_ready) q4.push_back('{exp_r, cyc, (cyc + 4 < 200)});
         if (bus16a.out_valid && bus16a.out_ready) begin
            n_checks++;
            if (q1.size() == 0) begin
               n_fail++; $display("FAIL w16s1_spurious: got %h expected no result", bus16a.Sum);
            end else begin
               e = q1.pop_front();
               if ({bus16a.Cout, bus16a.Sum} !== e.r || (e.lat && (cyc - e.c) != 1)) begin
                  n_fail++; $display("FAIL w16s1: got %h lat=%0d expected %h lat=1", {bus16a.Cout, bus16a.Sum}, cyc - e.c, e.r);
               end
            end
         end
         if (bus16b.out_valid && bus16b.out_ready) begin
            n_checks++;
            if (q4.size() == 0) begin
               n_fail++; $display("FAIL w16s4_spurious: got %h expected no result", bus16b.Sum);
            end else begin
               e = q4.pop_front();
               if ({bus16b.Cout, bus16b.Sum} !== e.r || (e.lat && (cyc - e.c) != 4)) begin
                  n_fail++; $display("FAIL w16s4: got %h lat=%0d expected %h lat=4", {bus16b.Cout, bus16b.Sum}, cyc - e.c, e.r);
               end
            end
         end
         tick();
      end
      n_checks++;
      if (q1.size() != 0 || q4.size() != 0) begin
         n_fail++; $display("FAIL w16_lost: got %0d/%0d pending expected 0/0", q1.size(), q4.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      set64(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
      bus64.out_ready = 1'b1;
      bus16a.in_valid = 1'b0; bus16a.A = '0; bus16a.B = '0; bus16a.Cin = 1'b0; bus16a.sub = 1'b0; bus16a.out_ready = 1'b1;
      bus16b.in_valid = 1'b0; bus16b.A = '0; bus16b.B = '0; bus16b.Cin = 1'b0; bus16b.sub = 1'b0; bus16b.out_ready = 1'b1;
      test_reset();
      test_carry_chain();
      test_back_to_back();
      test_sub();
      test_stall();
      test_reset_midflight();
      test_random64();
      test_w16_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit reached");
   end
endmodule

// File: doc/pipelined_bk_adder.md
PIPELINED_BK_ADDER -- requirements
Module: pipelined_bk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand width; legal values are powers of two, 8 to 128.
REQ-002 SHALL have parameter STAGES, default 2: pipeline register stages; legal range is 1 to log2(WIDTH).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the operand beat is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-007 SHALL have ports A and B, input, WIDTH bits each: the operands.
REQ-008 SHALL have port Cin, input, 1 bit: the carry-in.
REQ-009 SHALL have port sub, input, 1 bit: 1 computes A + ~B + Cin; 0 computes A + B + Cin.
REQ-010 SHALL have port out_valid, output, 1 bit: the result beat is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-012 SHALL have port Sum, output, WIDTH bits: the result.
REQ-013 SHALL have port Cout, output, 1 bit: the carry out of bit WIDTH-1.

Function
REQ-014 SHALL compute carries with a Brent-Kung prefix tree: an up-sweep of log2(WIDTH) levels, then a down-sweep of log2(WIDTH)-1 levels.
REQ-015 SHALL divide the prefix levels across STAGES register boundaries as evenly as possible, with the earlier stages taking the extra levels.
REQ-016 SHALL register the final Sum and Cout, so that latency is exactly STAGES cycles from the accept edge to out_valid under no stall.
REQ-017 SHALL accept a beat on any edge where in_valid and in_ready are both 1.
REQ-018 SHALL keep a valid bit for each stage; stage k loads when it is empty or when its content advances in the same cycle.
REQ-019 SHALL drive in_ready combinationally from the stage-1 load condition; in_ready SHALL NOT depend on in_valid.
REQ-020 SHALL hold the pipeline, while the pipeline is full and out_ready is 0: Sum, Cout and out_valid stay stable, and no beat is lost or duplicated.
REQ-021 SHALL collapse bubbles: an empty stage fills even while the output is stalled.
REQ-022 SHALL, when out_ready is 1 and the pipeline is full, accept a new beat and emit the oldest beat in the same cycle, sustaining 1 result per cycle.
REQ-023 SHALL deliver results in acceptance order.
REQ-024 SHALL wrap results modulo 2^WIDTH.
REQ-025 SHALL set Cout to bit WIDTH of the unbounded sum, including in sub mode: sub=1, Cin=1 gives Cout=1 when A>=B unsigned.
REQ-026 SHALL, when in_valid=0, capture no data and leave the stage valid bits unchanged except through advancement.

Reset
REQ-027 SHALL, while rst=1, immediately clear all stage valid bits and all pipeline data, set out_valid=0, Sum=0 and Cout=0; in_ready reads 1.
REQ-028 SHALL discard in-flight beats when rst is asserted mid-operation; no partial result may appear after rst deasserts.
REQ-029 SHALL accept a beat on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL, with BK_OVERFLOW_EN defined, add output port ovf, 1 bit: signed two's-complement overflow of the selected operation, pipelined alongside Sum, reset to 0, and held while stalled.
REQ-031 SHALL, with BK_OVERFLOW_EN undefined, have no ovf port and no overflow logic; all other behaviour is identical.

Verification
REQ-032 SHALL cover, at WIDTH=64 and STAGES=2: A=FFFFFFFF00000000, B=00000000FFFFFFFF, Cin=1, sub=0 -> 2 cycles later Sum=0000000000000000, Cout=1.
REQ-033 SHALL cover back-to-back beats A=1,B=1,Cin=1 then A=0,B=00000000FFFFFFFF,Cin=1 -> Sum=3, then Sum=0000000100000000, on consecutive cycles, both Cout=0.
REQ-034 SHALL cover sub=1, A=5, B=7, Cin=1 -> Sum=FFFFFFFFFFFFFFFE, Cout=0; with BK_OVERFLOW_EN defined, A=7FFFFFFFFFFFFFFF, B=1, sub=0, Cin=0 -> ovf=1.
REQ-035 SHALL cover out_ready held 0 for 5 cycles while 3 beats are offered -> in_ready=0 once both stages are full, the output stays stable, then 3 results drain in order with none lost.
REQ-036 SHALL cover rst pulsed with 2 beats in flight -> out_valid=0, Sum=0 and Cout=0 immediately, no stale result afterwards, and a new beat FFFFFFFFFFFFFFFF + 0 + Cin=1 -> Sum=0, Cout=1.
REQ-037 SHALL cover WIDTH=16 with STAGES=1 and STAGES=4 on random vectors against a reference model -> exact match, with latency equal to STAGES.
